// File: rtl/execution_block.sv
// Execute stage: ALU with flags, registered memory controls for datamemory,
// and a 16-iteration shift-add multiplier that stalls upstream.
module execution_block #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic [DW-1:0] data_in,
    input  logic [3:0]    op_dec,
    input  logic          mem_rw,
    input  logic          mem_en,
    input  logic          mem_mux_sel,
    output logic [DW-1:0] ans_ex,
    output logic [DW-1:0] DM_data,
    output logic          mem_rw_ex,
    output logic          mem_en_ex,
    output logic          mem_mux_sel_dm,
    output logic [3:0]    flag_ex,
    output logic          stall_ex
);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_SLL   = 4'h6;
    localparam logic [3:0] OP_SRL   = 4'h7;
    localparam logic [3:0] OP_SRA   = 4'h8;
    localparam logic [3:0] OP_PASSB = 4'h9;
    localparam logic [3:0] OP_MUL   = 4'hA;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] data_l_q, data_l_d;
    logic          rw_l_q, rw_l_d;
    logic          en_l_q, en_l_d;
    logic          sel_l_q, sel_l_d;

    logic [DW-1:0] ans_q, ans_d;
    logic [DW-1:0] dm_q, dm_d;
    logic          rw_q, rw_d;
    logic          en_q, en_d;
    logic          sel_q, sel_d;
    logic [3:0]    flag_q, flag_d;

    // Shifters carry one extra bit so the last bit shifted out lands in it;
    // with a zero shift amount that extra bit is 0, giving C=0 naturally.
    logic [3:0]          sh;
    logic [DW:0]         sll_w;
    logic [DW:0]         srl_w;
    logic signed [DW:0]  sra_w;

    assign sh    = B[3:0];
    assign sll_w = {1'b0, A} << sh;
    assign srl_w = {A, 1'b0} >> sh;
    assign sra_w = $signed({A, 1'b0}) >>> sh;

    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic          alu_v;
    logic [3:0]    alu_flags;

    // Single-cycle ALU result and carry/overflow.
    always_comb begin
        alu_res = A;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_dec)
            OP_ADD: begin
                {alu_c, alu_res} = {1'b0, A} + {1'b0, B};
                alu_v = (A[DW-1] == B[DW-1]) && (alu_res[DW-1] != A[DW-1]);
            end
            OP_SUB: begin
                alu_res = A - B;
                alu_c   = (A < B);
                alu_v   = (A[DW-1] != B[DW-1]) && (alu_res[DW-1] != A[DW-1]);
            end
            OP_AND:   alu_res = A & B;
            OP_OR:    alu_res = A | B;
            OP_XOR:   alu_res = A ^ B;
            OP_NOT:   alu_res = ~A;
            OP_SLL: begin
                alu_res = sll_w[DW-1:0];
                alu_c   = sll_w[DW];
            end
            OP_SRL: begin
                alu_res = srl_w[DW:1];
                alu_c   = srl_w[0];
            end
            OP_SRA: begin
                alu_res = sra_w[DW:1];
                alu_c   = sra_w[0];
            end
            OP_PASSB: alu_res = B;
            default:  alu_res = A;
        endcase
        alu_flags = {(alu_res == '0), alu_res[DW-1], alu_c, alu_v};
    end

    logic [DW-1:0] acc_sum;
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state logic: single-cycle issue, MUL acceptance, and the iteration loop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        data_l_d = data_l_q;
        rw_l_d   = rw_l_q;
        en_l_d   = en_l_q;
        sel_l_d  = sel_l_q;
        ans_d    = ans_q;
        dm_d     = dm_q;
        rw_d     = rw_q;
        en_d     = en_q;
        sel_d    = sel_q;
        flag_d   = flag_q;
        stall_ex = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_dec == OP_MUL) begin
                    stall_ex = 1'b1;
                    mcand_d  = A;
                    mplier_d = B;
                    acc_d    = '0;
                    cnt_d    = 4'd0;
                    data_l_d = data_in;
                    rw_l_d   = mem_rw;
                    en_l_d   = mem_en;
                    sel_l_d  = mem_mux_sel;
                    // Bubble: no memory access while the multiply runs.
                    rw_d     = 1'b0;
                    en_d     = 1'b0;
                    state_d  = ST_MUL;
                end else begin
                    ans_d  = alu_res;
                    flag_d = alu_flags;
                    dm_d   = data_in;
                    rw_d   = mem_rw;
                    en_d   = mem_en;
                    sel_d  = mem_mux_sel;
                end
            end
            ST_MUL: begin
                stall_ex = (cnt_q != 4'd15);
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    ans_d   = acc_sum;
                    flag_d  = {(acc_sum == '0), acc_sum[DW-1], 2'b00};
                    dm_d    = data_l_q;
                    rw_d    = rw_l_q;
                    en_d    = en_l_q;
                    sel_d   = sel_l_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reset) begin
            stall_ex = 1'b0;
        end
    end

    // State and output registers; reset discards any multiply in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            data_l_q <= '0;
            rw_l_q   <= 1'b0;
            en_l_q   <= 1'b0;
            sel_l_q  <= 1'b0;
            ans_q    <= '0;
            dm_q     <= '0;
            rw_q     <= 1'b0;
            en_q     <= 1'b0;
            sel_q    <= 1'b0;
            flag_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            data_l_q <= data_l_d;
            rw_l_q   <= rw_l_d;
            en_l_q   <= en_l_d;
            sel_l_q  <= sel_l_d;
            ans_q    <= ans_d;
            dm_q     <= dm_d;
            rw_q     <= rw_d;
            en_q     <= en_d;
            sel_q    <= sel_d;
            flag_q   <= flag_d;
        end
    end

    assign ans_ex         = ans_q;
    assign DM_data        = dm_q;
    assign mem_rw_ex      = rw_q;
    assign mem_en_ex      = en_q;
    assign mem_mux_sel_dm = sel_q;
    assign flag_ex        = flag_q;

endmodule

// File: doc/execution_block.md
# execution_block

Execute stage of the 16-bit pipelined processor, directly upstream of `datamemory`. Takes forwarded operands and decoded control from the decode stage. Computes the ALU result and condition flags. Registers `ans_ex`, store data `DM_data` and the memory controls `mem_rw_ex`, `mem_en_ex` and `mem_mux_sel_dm` that `datamemory` consumes. Single-cycle for all ops except MUL, which runs a 16-iteration shift-add sequence and stalls upstream.

## Interface
- `DW`, default 16, datapath width; only 16 is supported.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `A`  in  16  operand A (already forwarded).
- `B`  in  16  operand B (immediate already muxed in).
- `data_in`  in  16  store data for memory.
- `op_dec`  in  4  ALU opcode.
- `mem_rw`, `mem_en`, `mem_mux_sel`  in  1 each  decoded memory controls.
- `ans_ex`  out  16  registered ALU result; feeds `datamemory` as the address or writeback value.
- `DM_data`  out  16  registered store data.
- `mem_rw_ex`, `mem_en_ex`, `mem_mux_sel_dm`  out  1 each  registered memory controls.
- `flag_ex`  out  4  registered {Z,N,C,V}.
- `stall_ex`  out  1  combinational; upstream must hold all inputs while it is high.

## Operation
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT A.
  - 6 SLL: A<<B[3:0].
  - 7 SRL: A>>B[3:0].
  - 8 SRA: arithmetic right shift by B[3:0].
  - 9 PASSB.
  - A MUL: low 16 bits of unsigned A×B.
  - B–F: PASSA.
- Flags:
  - Z = result==0.
  - N = result[15].
  - C:
    - ADD: carry out of bit 15.
    - SUB: borrow, i.e. 1 when A<B unsigned.
    - Shifts: last bit shifted out, and 0 when the shift amount is 0.
    - All other ops: 0.
  - V: signed overflow for ADD/SUB; 0 for all other ops.
- State machine has two states, IDLE and MUL, with a 4-bit counter `cnt`.
- IDLE, op≠MUL, on each edge:
  - `ans_ex`, `flag_ex` ← computed values.
  - `DM_data` ← `data_in`.
  - The three controls ← their `*_in` values.
- IDLE, op==MUL, on the edge:
  - Latch A as the multiplicand, B as the multiplier, `data_in` and the three controls.
  - Clear the accumulator, `cnt` ← 0, go to MUL.
  - Register a bubble: `mem_en_ex`=0, `mem_rw_ex`=0. `ans_ex`, `flag_ex`, `DM_data` and `mem_mux_sel_dm` hold.
- MUL, each edge:
  - If multiplier[0]=1, accumulator += multiplicand.
  - Then multiplicand <<1, multiplier >>1.
  - `cnt` ← `cnt`+1, and the bubble outputs hold.
- MUL, edge with `cnt`==15 (the 16th iteration):
  - `ans_ex` ← final accumulator (mod 2^16).
  - Flags: Z and N from the result, C=V=0.
  - `DM_data` and the controls ← their latched copies.
  - Go to IDLE.
- `stall_ex` = (IDLE and op_dec==MUL) or (MUL and cnt≠15). It is forced to 0 while `reset` is high.
- Inputs are ignored while in MUL; only the latched copies are used.

## Timing
- Reset, asynchronous: all outputs go to 0 immediately, state → IDLE, `cnt`=0, accumulator and latches = 0. This includes reset asserted mid-MUL; the multiply is discarded, with no partial result and no memory access.
- Single-cycle ops: the result and controls appear 1 clock after being presented. Back-to-back ops issue every cycle with no bubbles.
- MUL timeline:
  - `stall_ex` is high for exactly 16 cycles: the presentation cycle plus `cnt` 0..14.
  - The result is registered on the 17th edge after presentation (E0 accept, E1..E16 iterate).
  - `mem_en_ex`=`mem_rw_ex`=0 from E0 through E15.
  - The next instruction is accepted on E16 itself; upstream advances on E16 because `stall_ex` is low before it.
- MUL followed immediately by MUL: the second MUL is presented after E16 and stalls again, with no lost cycle.
- Shift amount 0 returns A with C=0. Shift amount 15 is valid.

## Test plan
- Reset: assert `reset` with arbitrary inputs → all outputs 0 and `stall_ex`=0 at once, before any clock edge.
- ADD 0x7FFF+0x0001 with `mem_en`=1, `mem_rw`=0, `mem_mux_sel`=1 → after 1 edge: `ans_ex`=0x8000, N=1, V=1, C=0, Z=0, `mem_en_ex`=1, `mem_mux_sel_dm`=1.
- SUB 0x0003−0x0003 → 0x0000 with Z=1, C=0. Then SUB 0x0000−0x0001 → 0xFFFF with N=1, C=1. Results on consecutive cycles.
- MUL 0x0003×0x0005 with `mem_en`=1, `mem_rw`=1, `data_in`=0xFFFF:
  - `stall_ex` high for 16 cycles and `mem_en_ex`=0 throughout.
  - At E16: `ans_ex`=0x000F, `DM_data`=0xFFFF, `mem_rw_ex`=1, `mem_en_ex`=1.
  - A following MUL 0x0100×0x0100 → 0x0000 with Z=1.
- Reset asserted at `cnt`=7 of a MUL → outputs 0 immediately. After release, ADD 0x0001+0x0002 yields 0x0003 after 1 edge with no stall.
- Shifts:
  - SRA 0x8004 by 2 → 0xE001, C=0.
  - SLL 0xC000 by 1 → 0x8000, C=1.
  - SRL 0x0001 by 0 → 0x0001, C=0.
